imem_responder: RTL and testbench

Responder end of the AKARIN instruction bus: accepts word-addressed read and write requests from the fetch stage (or a program loader) and returns a single-cycle `ready_o` pulse with read data after a fixed, parameterised latency. It sits between the instruction bus and a local synchronous instruction RAM. It stands in for the instruction cache in simulation and FPGA builds.

---
 rtl/imem_responder_pkg.sv | 19 +
 rtl/imem_array.sv | 31 +++
 rtl/imem_responder.sv | 94 +++++++++
 tb/tb_imem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared types for the AKARIN instruction-bus responder
package imem_responder_pkg;

    localparam int IMEM_WAIT_W = 4;

    typedef enum logic [0:0] {
        IMEM_IDLE = 1'b0,
        IMEM_BUSY = 1'b1
    } imem_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] dataD;
        logic        read;
        logic        write;
        logic [3:0]  byteSel;
    } ibusReqPkt;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - single-port synchronous instruction RAM with per-byte write enables
module imem_array #(
    parameter int    ADDR_W    = 12,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q;

    // Read-before-write: a write cycle returns the old word, which the responder masks anyway.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int k = 0; k < 4; k++) begin
                if (we_i[k]) begin
                    mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-bus responder: FSM, wait counter, range check, response
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int    ADDR_W      = 12,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr_i,
    input  logic [31:0] dataD_i,
    output logic [31:0] dataQ_o,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [3:0]  byteSel_i,
    output logic        ready_o,
    output logic        err_o
);

    ibusReqPkt               req;
    imem_state_t             state_q, state_d;
    logic [IMEM_WAIT_W-1:0]  cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    zero_q, zero_d;
    logic                    err_q, err_d;
    logic                    accept;
    logic                    out_of_range;
    logic                    ram_en;
    logic [3:0]              ram_we;
    logic [31:0]             ram_rdata;

    assign req = '{addr: addr_i, dataD: dataD_i, read: read_i,
                   write: write_i, byteSel: byteSel_i};

    assign out_of_range = |req.addr[29:ADDR_W];
    // The ready cycle doubles as an acceptance slot so back-to-back requests see no bubble.
    assign accept       = (req.read | req.write) && ((state_q == IMEM_IDLE) || ready_q);
    assign ram_en       = accept && !out_of_range;
    assign ram_we       = (ram_en && req.write) ? req.byteSel : 4'b0000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        err_d   = err_q;
        if (accept) begin
            state_d = IMEM_BUSY;
            cnt_d   = IMEM_WAIT_W'(WAIT_CYCLES);
            zero_d  = req.write | out_of_range;
            err_d   = (req.read & req.write) | out_of_range;
        end else if (state_q == IMEM_BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = IMEM_IDLE;
            end
        end
        ready_d = (state_d == IMEM_BUSY) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    imem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (req.addr[ADDR_W-1:0]),
        .wdata_i (req.dataD),
        .rdata_o (ram_rdata)
    );

    assign ready_o = ready_q;
    assign dataQ_o = (ready_q && !zero_q) ? ram_rdata : 32'h0000_0000;
    assign err_o   = ready_q && err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed table-driven bench for imem_responder at WAIT_CYCLES 0 and 3
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        rd, wr;
    logic [3:0]  bs;
    logic [31:0] q0, q3;
    logic        rdy0, rdy3, e0, e3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Both instances share the request wires; every vector starts with both idle.
    imem_responder #(.ADDR_W(12), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .addr_i(addr), .dataD_i(wdata), .dataQ_o(q0),
        .read_i(rd), .write_i(wr), .byteSel_i(bs), .ready_o(rdy0), .err_o(e0)
    );

    imem_responder #(.ADDR_W(12), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
        .clk(clk), .rst(rst), .addr_i(addr), .dataD_i(wdata), .dataQ_o(q3),
        .read_i(rd), .write_i(wr), .byteSel_i(bs), .ready_o(rdy3), .err_o(e3)
    );

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bs;
        logic [31:0] exp_q;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t tab [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        rd = 1'b0;
        wr = 1'b0;
        repeat (n) tick();
        check("gap_quiet", {rdy0, rdy3, e0, e3}, 4'b0000);
        check("gap_data_zero", q0 | q3, 32'h0);
    endtask

    task automatic do_req(input int sel, input logic r, input logic w, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] gq, output logic ge, output int lat);
        rd = r; wr = w; addr = a; wdata = d; bs = b;
        lat = -1;
        gq  = 'x;
        ge  = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if ((sel == 0) ? rdy0 : rdy3) begin
                gq  = (sel == 0) ? q0 : q3;
                ge  = (sel == 0) ? e0 : e3;
                lat = c;
                break;
            end
        end
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gq;
        logic        ge;
        int          lat;
        int          pulses;

        tab[0]  = '{3, 1'b1, 1'b0, 30'h0000_0005, 32'h0,         4'h0,    32'h0505_0505, 1'b0, "rd5_w3"};
        tab[1]  = '{0, 1'b0, 1'b1, 30'h0000_0007, 32'hDEAD_BEEF, 4'b0101, 32'h0,         1'b0, "wr7_mask"};
        tab[2]  = '{0, 1'b1, 1'b0, 30'h0000_0007, 32'h0,         4'h0,    32'h07AD_07EF, 1'b0, "rd7_w0"};
        tab[3]  = '{3, 1'b1, 1'b0, 30'h0000_0007, 32'h0,         4'h0,    32'h07AD_07EF, 1'b0, "rd7_w3"};
        tab[4]  = '{0, 1'b1, 1'b0, 30'h1000_0000, 32'h0,         4'h0,    32'h0,         1'b1, "rd_oor_hi"};
        tab[5]  = '{0, 1'b1, 1'b0, 30'h0000_0000, 32'h0,         4'h0,    32'h0,         1'b0, "rd0_after_oor"};
        tab[6]  = '{0, 1'b1, 1'b1, 30'h0000_0002, 32'h1234_5678, 4'hF,    32'h0,         1'b1, "rdwr2"};
        tab[7]  = '{0, 1'b1, 1'b0, 30'h0000_0002, 32'h0,         4'h0,    32'h1234_5678, 1'b0, "rd2_after_rdwr"};
        tab[8]  = '{3, 1'b0, 1'b1, 30'h0000_0009, 32'hAABB_CCDD, 4'b1100, 32'h0,         1'b0, "wr9_upper"};
        tab[9]  = '{3, 1'b1, 1'b0, 30'h0000_0009, 32'h0,         4'h0,    32'hAABB_0909, 1'b0, "rd9_w3"};
        tab[10] = '{3, 1'b1, 1'b0, 30'h3FFF_FFFF, 32'h0,         4'h0,    32'h0,         1'b1, "rd_oor_all_w3"};
        tab[11] = '{0, 1'b1, 1'b0, 30'h0000_1000, 32'h0,         4'h0,    32'h0,         1'b1, "rd_oor_lowbit"};
        tab[12] = '{0, 1'b0, 1'b1, 30'h0000_0FFF, 32'h55AA_33CC, 4'hF,    32'h0,         1'b0, "wr_top_word"};
        tab[13] = '{0, 1'b1, 1'b0, 30'h0000_0FFF, 32'h0,         4'h0,    32'h55AA_33CC, 1'b0, "rd_top_word"};
        tab[14] = '{0, 1'b0, 1'b1, 30'h1000_0005, 32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, "wr_oor_dropped"};
        tab[15] = '{0, 1'b1, 1'b0, 30'h0000_0005, 32'h0,         4'h0,    32'h0505_0505, 1'b0, "rd5_no_alias"};

        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; bs = '0;
        repeat (3) tick();
        check("reset_ready", {rdy0, rdy3}, 2'b00);
        check("reset_err", {e0, e3}, 2'b00);
        check("reset_data", q0 | q3, 32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_req(3, 1'b0, 1'b1, 30'(i), 32'(i) * 32'h0101_0101, 4'hF, gq, ge, lat);
            check("preload_lat", 32'(lat), 32'd4);
            check("preload_data", gq, 32'h0);
            idle_gap(6);
        end

        // Streaming reads at zero wait: a new address every cycle, a strobe every cycle.
        rd = 1'b1;
        addr = 30'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_ready", {31'b0, rdy0}, 32'd1);
            check("b2b_data", q0, 32'(k) * 32'h0101_0101);
            addr = 30'(k + 1);
        end
        rd = 1'b0;
        tick();
        check("b2b_end_ready", {31'b0, rdy0}, 32'd0);
        check("b2b_end_data", q0, 32'h0);
        idle_gap(6);

        // Address wiggled while busy must not change the response.
        rd = 1'b1;
        addr = 30'd5;
        for (int k = 1; k <= 4; k++) begin
            tick();
            addr = 30'(6 + k);
            if (k < 4) begin
                check("hold_not_ready", {31'b0, rdy3}, 32'd0);
            end else begin
                check("hold_ready", {31'b0, rdy3}, 32'd1);
                check("hold_data", q3, 32'h0505_0505);
            end
        end
        rd = 1'b0;
        idle_gap(6);

        for (int v = 0; v < 16; v++) begin
            do_req(tab[v].sel, tab[v].rd, tab[v].wr, tab[v].addr, tab[v].wdata, tab[v].bs, gq, ge, lat);
            check({tab[v].name, "_data"}, gq, tab[v].exp_q);
            check({tab[v].name, "_err"}, {31'b0, ge}, {31'b0, tab[v].exp_err});
            check({tab[v].name, "_lat"}, 32'(lat), (tab[v].sel == 0) ? 32'd1 : 32'd4);
            idle_gap(6);
        end

        // Reset two cycles into a WAIT_CYCLES=3 read: the response must vanish for good.
        rd = 1'b1;
        addr = 30'd4;
        tick();
        tick();
        rst = 1'b0;
        rd = 1'b0;
        #1;
        check("rst_mid_ready", {31'b0, rdy3}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rdy3 || rdy0) pulses++;
        end
        check("rst_no_spurious", 32'(pulses), 32'd0);
        do_req(3, 1'b1, 1'b0, 30'd4, 32'h0, 4'h0, gq, ge, lat);
        check("post_rst_data", gq, 32'h0404_0404);
        check("post_rst_lat", 32'(lat), 32'd4);
        check("post_rst_err", {31'b0, ge}, 32'd0);
        idle_gap(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
